prv32_alu: RTL and testbench
============================

Name: prv32_alu

Overview:
- 32-bit RV32I integer ALU for the pipelined core's execute stage.
- Performs the add, sub, logic, shift and set-less-than operations for all R- and I-type instructions, plus a pass-through of operand b.
- Result and the four condition flags (carry, zero, overflow, sign) are registered, so the block is a single pipeline stage with 1-cycle latency.
- Branch logic downstream consumes the flags.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; the flag definitions below assume bit 31 is the MSB.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  32  operand A (rs1)
- b  input  32  operand B (rs2 or immediate)
- shamt  input  5  shift amount; shifts never use b
- alufn  input  4  operation select
- r  output  32  registered result
- cf  output  1  registered carry flag
- zf  output  1  registered zero flag
- vf  output  1  registered overflow flag
- sf  output  1  registered sign flag

Behaviour:
- Fully synchronous. All outputs update on the rising edge of clk.
- Latency is 1 cycle: inputs sampled at edge N appear on r and the flags after edge N.
- No handshake; a new operation is accepted every cycle.
- Reset: when rst=1 at a rising edge, r=0 and cf=zf=vf=sf=0. Reset has priority over everything. The first valid result appears on the first edge with rst=0.
- Adder path is shared and always computed:
  - b_eff = alufn[0] ? ~b : b
  - {carry, sum} = a + b_eff + alufn[0], a 33-bit result.
- Flags are always taken from the adder path, for every alufn code:
  - cf = carry
  - zf = (sum == 0)
  - sf = sum[31]
  - vf = (sum[31] ^ a[31]) & (sum[31] ^ b_eff[31])
- alufn encodings (defines.v macro names) and the result selected for r:
  - 0000 ALU_ADD: sum
  - 0001 ALU_SUB: sum (a - b)
  - 0011 ALU_PASS: b
  - 0100 ALU_OR: a | b
  - 0101 ALU_AND: a & b
  - 0111 ALU_XOR: a ^ b
  - 1000 ALU_SRL: a >> shamt, logical
  - 1010 ALU_SRA: a >>> shamt, sign-filled from a[31]
  - 1001 ALU_SLL: a << shamt
  - 1101 ALU_SLT: {31'b0, (sf != vf)}. The subtract path is active because alufn[0]=1.
  - 1111 ALU_SLTU: {31'b0, ~cf}, from the subtract path.
  - Any other code: r = 0. Flags still follow the adder path.
- Arithmetic is modulo 2^32; there is no trap on overflow.
- Boundary values:
  - shamt=0: every shift returns a unchanged.
  - shamt=31: SRA returns all copies of a[31].
  - a=b under SUB: zf=1, cf=1 (no borrow), SLTU gives 0.
- Changing alufn mid-stream takes effect at the next edge only. There is no internal state other than the output registers.

Test Plan:
- Reset then arithmetic:
  - Assert rst for 2 cycles -> r=0, all flags 0.
  - Release rst; a=32, b=100, ADD -> next cycle r=132.
  - SUB with the same operands -> r=0xFFFFFFBC (-68), sf=1, cf=0, zf=0.
  - PASS -> r=100.
- Logic: a=0x2A, b=0x15:
  - OR -> 0x3F
  - AND -> 0x0
  - XOR -> 0x3F
- Shifts: a=255:
  - SRL with shamt=1 -> 127
  - SRA with shamt=5 -> 7
  - SLL with shamt=2 -> 1020
  - a=0x80000000, SRA with shamt=4 -> 0xF8000000
- Compare: a=1, b=0xFFFFFFFF:
  - SLT -> 0
  - SLTU -> 1
  - a=b=5: SLT -> 0, SLTU -> 0, and zf=1 during SUB.
- Flags: a=b=0x80000000, ADD -> r=0, cf=1, zf=1, vf=1, sf=0. Also a=0x7FFFFFFF, b=1, ADD -> vf=1, sf=1, cf=0.
- Pipelining and reset mid-stream:
  - Apply back-to-back ops on consecutive cycles -> each result appears exactly one cycle later.
  - Assert rst while ops are streaming -> outputs read 0 at the next edge.
  - An undefined alufn of 0010 -> r=0.

Source files
------------

// File: rtl/prv32_alu.sv
// RV32I execute-stage ALU: shared adder for arithmetic, compares and flags,
// one bidirectional log shifter, and a registered result/flag stage.
module prv32_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    input  logic [3:0]       alufn,
    output logic [WIDTH-1:0] r,
    output logic             cf,
    output logic             zf,
    output logic             vf,
    output logic             sf
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             flag_c;
    logic             flag_z;
    logic             flag_v;
    logic             flag_s;

    // alufn[0] selects subtract for every code, so SLT/SLTU compare through a - b
    assign b_eff = alufn[0] ? ~b : b;
    assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, alufn[0]};

    assign flag_c = carry;
    assign flag_z = (sum == '0);
    assign flag_s = sum[WIDTH-1];
    assign flag_v = (sum[WIDTH-1] ^ a[WIDTH-1]) & (sum[WIDTH-1] ^ b_eff[WIDTH-1]);

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = '0;
        for (int i = 0; i < WIDTH; i++) begin
            y[i] = x[WIDTH-1-i];
        end
        return y;
    endfunction

    // Left shifts reuse the right shifter by reversing the operand and result.
    logic             shift_left;
    logic             shift_fill;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] stage_1;
    logic [WIDTH-1:0] stage_2;
    logic [WIDTH-1:0] stage_4;
    logic [WIDTH-1:0] stage_8;
    logic [WIDTH-1:0] stage_16;
    logic [WIDTH-1:0] shift_out;

    assign shift_left = (alufn == ALU_SLL);
    assign shift_fill = (alufn == ALU_SRA) & a[WIDTH-1];
    assign shift_in   = shift_left ? bit_reverse(a) : a;

    assign stage_1  = shamt[0] ? {{1{shift_fill}},  shift_in[WIDTH-1:1]}  : shift_in;
    assign stage_2  = shamt[1] ? {{2{shift_fill}},  stage_1[WIDTH-1:2]}   : stage_1;
    assign stage_4  = shamt[2] ? {{4{shift_fill}},  stage_2[WIDTH-1:4]}   : stage_2;
    assign stage_8  = shamt[3] ? {{8{shift_fill}},  stage_4[WIDTH-1:8]}   : stage_4;
    assign stage_16 = shamt[4] ? {{16{shift_fill}}, stage_8[WIDTH-1:16]}  : stage_8;

    assign shift_out = shift_left ? bit_reverse(stage_16) : stage_16;

    logic [WIDTH-1:0] result;

    always_comb begin
        result = '0;
        case (alufn)
            ALU_ADD,
            ALU_SUB:  result = sum;
            ALU_PASS: result = b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_XOR:  result = a ^ b;
            ALU_SRL,
            ALU_SLL,
            ALU_SRA:  result = shift_out;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, flag_s != flag_v};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, ~flag_c};
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r  <= '0;
            cf <= 1'b0;
            zf <= 1'b0;
            vf <= 1'b0;
            sf <= 1'b0;
        end else begin
            r  <= result;
            cf <= flag_c;
            zf <= flag_z;
            vf <= flag_v;
            sf <= flag_s;
        end
    end

endmodule

// File: tb/tb_prv32_alu.sv
// Directed-vector bench for prv32_alu: hand-computed results and flags,
// back-to-back issue, reset in mid-stream and undefined opcodes.
module tb_prv32_alu;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [3:0]  alufn;
    logic [31:0] r;
    logic        cf;
    logic        zf;
    logic        vf;
    logic        sf;

    int n_checks = 0;
    int n_fail   = 0;

    prv32_alu dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .shamt (shamt),
        .alufn (alufn),
        .r     (r),
        .cf    (cf),
        .zf    (zf),
        .vf    (vf),
        .sf    (sf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one operation, then sample just after the capturing edge.
    task automatic op(input logic [3:0] fn, input logic [31:0] op_a, input logic [31:0] op_b,
                      input logic [4:0] sh);
        alufn = fn;
        a     = op_a;
        b     = op_b;
        shamt = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [3:0] exp_czvs);
        check({tag, ".cf"}, {31'b0, cf}, {31'b0, exp_czvs[3]});
        check({tag, ".zf"}, {31'b0, zf}, {31'b0, exp_czvs[2]});
        check({tag, ".vf"}, {31'b0, vf}, {31'b0, exp_czvs[1]});
        check({tag, ".sf"}, {31'b0, sf}, {31'b0, exp_czvs[0]});
    endtask

    initial begin
        rst   = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        shamt = 5'd3;
        alufn = ALU_ADD;
        repeat (2) @(posedge clk);
        #1;
        check("reset.r", r, 32'h0);
        check_flags("reset", 4'b0000);

        rst = 1'b0;
        op(ALU_ADD, 32'd32, 32'd100, 5'd0);
        check("add.r", r, 32'd132);
        check_flags("add", 4'b0000);

        // Output must hold until the next edge even though inputs have changed.
        alufn = ALU_SUB;
        #1;
        check("hold.r", r, 32'd132);
        @(posedge clk);
        #1;
        check("sub.r", r, 32'hFFFF_FFBC);
        check_flags("sub", 4'b0001);

        op(ALU_PASS, 32'd32, 32'd100, 5'd0);
        check("pass.r", r, 32'd100);

        op(ALU_OR,  32'h2A, 32'h15, 5'd0);
        check("or.r", r, 32'h3F);
        op(ALU_AND, 32'h2A, 32'h15, 5'd0);
        check("and.r", r, 32'h0);
        op(ALU_XOR, 32'h2A, 32'h15, 5'd0);
        check("xor.r", r, 32'h3F);

        op(ALU_SRL, 32'd255, 32'h0, 5'd1);
        check("srl1.r", r, 32'd127);
        op(ALU_SRA, 32'd255, 32'h0, 5'd5);
        check("sra5.r", r, 32'd7);
        op(ALU_SLL, 32'd255, 32'h0, 5'd2);
        check("sll2.r", r, 32'd1020);
        op(ALU_SRA, 32'h8000_0000, 32'h0, 5'd4);
        check("sra_neg.r", r, 32'hF800_0000);
        op(ALU_SRL, 32'h8000_0000, 32'h0, 5'd4);
        check("srl_neg.r", r, 32'h0800_0000);
        op(ALU_SRA, 32'h8000_0001, 32'h0, 5'd31);
        check("sra31.r", r, 32'hFFFF_FFFF);
        op(ALU_SRL, 32'h8000_0000, 32'h0, 5'd31);
        check("srl31.r", r, 32'h0000_0001);
        op(ALU_SLL, 32'h0000_0001, 32'h0, 5'd31);
        check("sll31.r", r, 32'h8000_0000);
        op(ALU_SRL, 32'h8000_00F0, 32'h0, 5'd0);
        check("srl0.r", r, 32'h8000_00F0);
        op(ALU_SRA, 32'h8000_00F0, 32'h0, 5'd0);
        check("sra0.r", r, 32'h8000_00F0);
        op(ALU_SLL, 32'h8000_00F0, 32'h0, 5'd0);
        check("sll0.r", r, 32'h8000_00F0);
        // shamt must be used, never b
        op(ALU_SLL, 32'h0000_0003, 32'd8, 5'd4);
        check("sll_shamt.r", r, 32'h0000_0030);

        op(ALU_SLT,  32'd1, 32'hFFFF_FFFF, 5'd0);
        check("slt_pos_neg.r", r, 32'd0);
        op(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 5'd0);
        check("sltu_small_big.r", r, 32'd1);
        op(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_neg_pos.r", r, 32'd1);
        op(ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 5'd0);
        check("slt_ovf.r", r, 32'd1);
        op(ALU_SLT,  32'd5, 32'd5, 5'd0);
        check("slt_eq.r", r, 32'd0);
        op(ALU_SLTU, 32'd5, 32'd5, 5'd0);
        check("sltu_eq.r", r, 32'd0);
        op(ALU_SUB,  32'd5, 32'd5, 5'd0);
        check("sub_eq.r", r, 32'd0);
        check_flags("sub_eq", 4'b1100);

        op(ALU_ADD, 32'h8000_0000, 32'h8000_0000, 5'd0);
        check("add_wrap.r", r, 32'h0);
        check_flags("add_wrap", 4'b1110);
        op(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("add_ovf.r", r, 32'h8000_0000);
        check_flags("add_ovf", 4'b0011);

        op(4'b0010, 32'd5, 32'd5, 5'd0);
        check("undef0010.r", r, 32'h0);
        check_flags("undef0010", 4'b0000);
        op(4'b1110, 32'hFFFF_FFFF, 32'h1234_5678, 5'd3);
        check("undef1110.r", r, 32'h0);

        // Back-to-back stream followed by reset in mid-stream.
        op(ALU_ADD, 32'd10, 32'd20, 5'd0);
        check("b2b0.r", r, 32'd30);
        op(ALU_SUB, 32'd10, 32'd20, 5'd0);
        check("b2b1.r", r, 32'hFFFF_FFF6);
        op(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0);
        check("b2b2.r", r, 32'h0F0F_F0F0);
        rst = 1'b1;
        op(ALU_SUB, 32'd10, 32'd20, 5'd0);
        check("rst_mid.r", r, 32'h0);
        check_flags("rst_mid", 4'b0000);
        rst = 1'b0;
        op(ALU_ADD, 32'd1, 32'd2, 5'd0);
        check("post_rst.r", r, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
